// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: IICMB register map, command codes, CMDR status bits and sequencer types.
package i2c_seq_pkg;
    localparam logic [1:0] ADR_CSR  = 2'd0;
    localparam logic [1:0] ADR_DPR  = 2'd1;
    localparam logic [1:0] ADR_CMDR = 2'd2;
    localparam logic [1:0] ADR_FSMR = 2'd3;
    localparam logic [2:0] CMD_WRITE    = 3'b001;
    localparam logic [2:0] CMD_READ_ACK = 3'b010;
    localparam logic [2:0] CMD_READ_NAK = 3'b011;
    localparam logic [2:0] CMD_START    = 3'b100;
    localparam logic [2:0] CMD_STOP     = 3'b101;
    localparam logic [2:0] CMD_SET_BUS  = 3'b110;
    localparam logic [7:0] CSR_ON  = 8'hC0;
    localparam logic [7:0] CSR_OFF = 8'h00;
    localparam int ST_DON = 7;
    localparam int ST_NAK = 6;
    localparam int ST_AL  = 5;
    localparam int ST_ERR = 4;
    typedef enum logic [1:0] {ERR_OK, ERR_NAK, ERR_AL, ERR_CMD} err_e;
    typedef enum logic [4:0] {
        S_INIT, S_IDLE, S_BUS_DPR, S_BUS_CMD, S_START, S_ADDR_DPR, S_ADDR_CMD,
        S_WR_WAIT, S_WR_DPR, S_WR_CMD, S_RD_CMD, S_RD_DPR, S_RD_OUT,
        S_STOP, S_WAIT_IRQ, S_STAT, S_DONE, S_TO_OFF, S_TO_ON
    } state_e;
endpackage

// File: rtl/wb_master_port.sv
// wb_master_port: single outstanding Wishbone transfer; o_done pulses the cycle after ack with o_rdata valid.
module wb_master_port #(
    parameter int AW = 2,
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          i_start,
    input  logic          i_we,
    input  logic [AW-1:0] i_adr,
    input  logic [DW-1:0] i_dat,
    output logic          o_done,
    output logic [DW-1:0] o_rdata,
    output logic          o_cyc,
    output logic          o_stb,
    output logic          o_we,
    output logic [AW-1:0] o_adr,
    output logic [DW-1:0] o_dat,
    input  logic [DW-1:0] i_wb_dat,
    input  logic          i_ack
);
    logic          r_cyc, r_we, r_done;
    logic [AW-1:0] r_adr;
    logic [DW-1:0] r_dat, r_rdata;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_rdata <= '0;
        end else begin
            r_done <= r_cyc & i_ack;
            if (r_cyc && i_ack) begin
                r_cyc   <= 1'b0;
                r_we    <= 1'b0;
                r_rdata <= i_wb_dat;
            end else if (!r_cyc && i_start) begin
                r_cyc <= 1'b1;
                r_we  <= i_we;
                r_adr <= i_adr;
                r_dat <= i_dat;
            end
        end
    end

    assign o_cyc   = r_cyc;
    assign o_stb   = r_cyc;
    assign o_we    = r_we;
    assign o_adr   = r_adr;
    assign o_dat   = r_dat;
    assign o_done  = r_done;
    assign o_rdata = r_rdata;
endmodule

// File: rtl/i2c_wb_sequencer.sv
// i2c_wb_sequencer: drives IICMB CSR/DPR/CMDR traffic for one I2C transaction per request.
// SEQ_TIMEOUT_EN adds an irq watchdog that resets the core and reports err=3.
module i2c_wb_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int LEN_WIDTH      = 7,
    parameter int IRQ_TIMEOUT    = 65535
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [3:0]                req_bus_i,
    input  logic [I2C_ADDR_WIDTH-1:0] req_addr_i,
    input  logic                      req_rd_i,
    input  logic [LEN_WIDTH-1:0]      req_len_i,
    input  logic                      wdata_valid_i,
    input  logic [7:0]                wdata_i,
    output logic                      wdata_ready_o,
    output logic                      rdata_valid_o,
    output logic [7:0]                rdata_o,
    input  logic                      rdata_ready_i,
    output logic                      done_o,
    output logic [1:0]                err_o,
    output logic                      cyc_o,
    output logic                      stb_o,
    output logic                      we_o,
    output logic [WB_ADDR_WIDTH-1:0]  adr_o,
    output logic [WB_DATA_WIDTH-1:0]  dat_o,
    input  logic [WB_DATA_WIDTH-1:0]  dat_i,
    input  logic                      ack_i,
    input  logic                      irq_i
);
    localparam logic [WB_ADDR_WIDTH-1:0] A_CSR  = WB_ADDR_WIDTH'(ADR_CSR);
    localparam logic [WB_ADDR_WIDTH-1:0] A_DPR  = WB_ADDR_WIDTH'(ADR_DPR);
    localparam logic [WB_ADDR_WIDTH-1:0] A_CMDR = WB_ADDR_WIDTH'(ADR_CMDR);

    function automatic logic [WB_DATA_WIDTH-1:0] cmd(input logic [2:0] c);
        return WB_DATA_WIDTH'(c);
    endfunction

    state_e                    r_state, w_next, r_ret, w_ret;
    err_e                      r_err;
    logic [3:0]                r_bus, r_cache;
    logic                      r_cache_v, r_rd, r_pend;
    logic [I2C_ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]      r_len, r_cnt;
    logic [7:0]                r_wbyte, r_rdata;
    logic                      w_issue, w_we, w_start, w_done, w_last;
    logic [WB_ADDR_WIDTH-1:0]  w_adr;
    logic [WB_DATA_WIDTH-1:0]  w_dat, w_rdata;

`ifdef SEQ_TIMEOUT_EN
    localparam int WDOG_W = $clog2(IRQ_TIMEOUT + 1);
    logic [WDOG_W-1:0] r_wdog;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_wdog <= '0;
        else         r_wdog <= (r_state == S_WAIT_IRQ) ? r_wdog + 1'b1 : '0;
    end
`endif

    assign w_last  = r_cnt == LEN_WIDTH'(1);
    assign w_start = w_issue & ~r_pend;

    // Each issuing state requests one transfer and advances on its done pulse; r_ret is where WAIT_IRQ resumes.
    always_comb begin
        w_next  = r_state;
        w_ret   = r_ret;
        w_issue = 1'b0;
        w_we    = 1'b1;
        w_adr   = A_CMDR;
        w_dat   = '0;
        case (r_state)
            S_INIT:     begin w_issue = 1'b1; w_adr = A_CSR; w_dat = WB_DATA_WIDTH'(CSR_ON); if (w_done) w_next = S_IDLE; end
            S_IDLE:     if (req_valid_i) w_next = (r_cache_v && req_bus_i == r_cache) ? S_START : S_BUS_DPR;
            S_BUS_DPR:  begin w_issue = 1'b1; w_adr = A_DPR; w_dat = WB_DATA_WIDTH'(r_bus); if (w_done) w_next = S_BUS_CMD; end
            S_BUS_CMD:  begin w_issue = 1'b1; w_dat = cmd(CMD_SET_BUS); w_ret = S_START; if (w_done) w_next = S_WAIT_IRQ; end
            S_START:    begin w_issue = 1'b1; w_dat = cmd(CMD_START); w_ret = S_ADDR_DPR; if (w_done) w_next = S_WAIT_IRQ; end
            S_ADDR_DPR: begin w_issue = 1'b1; w_adr = A_DPR; w_dat = WB_DATA_WIDTH'({r_addr, r_rd}); if (w_done) w_next = S_ADDR_CMD; end
            S_ADDR_CMD: begin
                w_issue = 1'b1;
                w_dat   = cmd(CMD_WRITE);
                w_ret   = (r_len == '0) ? S_STOP : r_rd ? S_RD_CMD : S_WR_WAIT;
                if (w_done) w_next = S_WAIT_IRQ;
            end
            S_WR_WAIT:  if (wdata_valid_i) w_next = S_WR_DPR;
            S_WR_DPR:   begin w_issue = 1'b1; w_adr = A_DPR; w_dat = WB_DATA_WIDTH'(r_wbyte); if (w_done) w_next = S_WR_CMD; end
            S_WR_CMD:   begin w_issue = 1'b1; w_dat = cmd(CMD_WRITE); w_ret = w_last ? S_STOP : S_WR_WAIT; if (w_done) w_next = S_WAIT_IRQ; end
            S_RD_CMD:   begin w_issue = 1'b1; w_dat = cmd(w_last ? CMD_READ_NAK : CMD_READ_ACK); w_ret = S_RD_DPR; if (w_done) w_next = S_WAIT_IRQ; end
            S_RD_DPR:   begin w_issue = 1'b1; w_we = 1'b0; w_adr = A_DPR; if (w_done) w_next = S_RD_OUT; end
            S_RD_OUT:   if (rdata_ready_i) w_next = (r_cnt == '0) ? S_STOP : S_RD_CMD;
            S_STOP:     begin w_issue = 1'b1; w_dat = cmd(CMD_STOP); w_ret = S_DONE; if (w_done) w_next = S_WAIT_IRQ; end
            S_WAIT_IRQ: begin
                if (irq_i) w_next = S_STAT;
`ifdef SEQ_TIMEOUT_EN
                else if (r_wdog == WDOG_W'(IRQ_TIMEOUT - 1)) w_next = S_TO_OFF;
`endif
            end
            S_STAT:     begin
                w_issue = 1'b1;
                w_we    = 1'b0;
                if (w_done) w_next = (w_rdata[ST_DON] || r_ret == S_DONE) ? r_ret : w_rdata[ST_AL] ? S_DONE : S_STOP;
            end
            S_TO_OFF:   begin w_issue = 1'b1; w_adr = A_CSR; w_dat = WB_DATA_WIDTH'(CSR_OFF); if (w_done) w_next = S_TO_ON; end
            S_TO_ON:    begin w_issue = 1'b1; w_adr = A_CSR; w_dat = WB_DATA_WIDTH'(CSR_ON); if (w_done) w_next = S_DONE; end
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_INIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_INIT;
            r_ret     <= S_INIT;
            r_err     <= ERR_OK;
            r_pend    <= 1'b0;
            r_bus     <= '0;
            r_cache   <= '0;
            r_cache_v <= 1'b0;
            r_addr    <= '0;
            r_rd      <= 1'b0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_wbyte   <= '0;
            r_rdata   <= '0;
        end else begin
            r_state <= w_next;
            r_ret   <= w_ret;
            r_pend  <= w_start | (r_pend & ~w_done);
            if (r_state == S_IDLE && req_valid_i) begin
                r_bus  <= req_bus_i;
                r_addr <= req_addr_i;
                r_rd   <= req_rd_i;
                r_len  <= req_len_i;
                r_cnt  <= req_len_i;
                r_err  <= ERR_OK;
            end
            if (r_state == S_WR_WAIT && wdata_valid_i) r_wbyte <= wdata_i;
            if ((r_state == S_WR_CMD || r_state == S_RD_DPR) && w_done) r_cnt <= r_cnt - 1'b1;
            if (r_state == S_RD_DPR && w_done) r_rdata <= w_rdata[7:0];
            // First failure wins so a later STOP status cannot mask the original cause.
            if (r_state == S_STAT && w_done && !w_rdata[ST_DON] && r_err == ERR_OK)
                r_err <= w_rdata[ST_AL] ? ERR_AL : w_rdata[ST_NAK] ? ERR_NAK : ERR_CMD;
            if (r_state == S_TO_OFF) r_err <= ERR_CMD;
            if (r_state == S_DONE) begin
                r_cache_v <= r_err == ERR_OK;
                r_cache   <= r_bus;
            end
        end
    end

    wb_master_port #(.AW(WB_ADDR_WIDTH), .DW(WB_DATA_WIDTH)) u_wb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .i_start  (w_start),
        .i_we     (w_we),
        .i_adr    (w_adr),
        .i_dat    (w_dat),
        .o_done   (w_done),
        .o_rdata  (w_rdata),
        .o_cyc    (cyc_o),
        .o_stb    (stb_o),
        .o_we     (we_o),
        .o_adr    (adr_o),
        .o_dat    (dat_o),
        .i_wb_dat (dat_i),
        .i_ack    (ack_i)
    );

    assign req_ready_o   = r_state == S_IDLE;
    assign wdata_ready_o = (r_state == S_WR_WAIT) & wdata_valid_i;
    assign rdata_valid_o = r_state == S_RD_OUT;
    assign rdata_o       = r_rdata;
    assign done_o        = r_state == S_DONE;
    assign err_o         = r_err;
endmodule
